// File: rtl/sum_reduce_sched.sv
// sum_reduce_sched: sums N captured operands over several cycles on P shared adders.
// Each RUN edge pairs the lowest live slots and packs the unpaired ones down behind the adder results.
module sum_reduce_sched #(
    parameter int N  = 20,
    parameter int W  = 5,
    parameter int P  = 6,
    parameter int OW = 10,
    parameter int CW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N*W-1:0]  nums,
    output logic            busy,
    output logic            done,
    output logic [OW-1:0]   sum,
    output logic [CW-1:0]   cycles
);
    localparam int LW = $clog2(N + 1);
    localparam int IW = $clog2(N);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state_q, state_d;
    logic [OW-1:0] a_q [N];
    logic [OW-1:0] a_d [N];
    logic [OW-1:0] a_red [N];
    logic [OW-1:0] add [N];
    logic [LW-1:0] l_q, l_d, half, pairs;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc, cycles_q, cycles_d;
    logic [OW-1:0] sum_q, sum_d;
    logic          done_q, done_d;
    // Exactly P physical adders on fixed slot pairs; remaining entries are tied off.
    for (genvar g = 0; g < N; g++) begin : g_add
        if (g < P && 2 * g + 1 < N) begin : g_on
            assign add[g] = a_q[2*g] + a_q[2*g+1];
        end else begin : g_off
            assign add[g] = '0;
        end
    end
    always_comb begin
        half    = l_q >> 1;
        pairs   = (int'(half) > P) ? LW'(P) : half;
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        for (int k = 0; k < N; k++)
            a_red[k] = (k < int'(pairs)) ? add[IW'(k)] :
                       (k + int'(pairs) < N) ? a_q[IW'(k + int'(pairs))] : '0;
    end
    always_comb begin
        state_d  = state_q;
        l_d      = l_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        done_d   = 1'b0;
        sum_d    = sum_q;
        cycles_d = cycles_q;
        if (state_q == IDLE) begin
            if (start) begin
                for (int k = 0; k < N; k++) a_d[k] = OW'(nums[k*W +: W]);
                l_d     = LW'(N);
                cnt_d   = '0;
                state_d = RUN;
            end
        end else begin
            a_d   = a_red;
            l_d   = l_q - pairs;
            cnt_d = cnt_inc;
            if (l_d == LW'(1)) begin
                sum_d    = a_red[0];
                cycles_d = cnt_inc;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            l_q      <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cycles_q <= '0;
            for (int k = 0; k < N; k++) a_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            l_q      <= l_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            sum_q    <= sum_d;
            cycles_q <= cycles_d;
            a_q      <= a_d;
        end
    end
    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign sum    = sum_q;
    assign cycles = cycles_q;
endmodule

// File: tb/tb_sum_reduce_sched.sv
// tb_sum_reduce_sched: directed checks of sum_reduce_sched at defaults, OW=8 and N=4/P=1.
module tb_sum_reduce_sched;
    logic        clk = 1'b0;
    logic        rst, start0, start2;
    logic [99:0] nums0;
    logic [19:0] nums2;
    logic        busy0, done0, busy1, done1, busy2, done2;
    logic [9:0]  sum0, sum2;
    logic [7:0]  sum1;
    logic [4:0]  cyc0, cyc1, cyc2;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    sum_reduce_sched d0 (.clk(clk), .rst(rst), .start(start0), .nums(nums0),
        .busy(busy0), .done(done0), .sum(sum0), .cycles(cyc0));
    sum_reduce_sched #(.OW(8)) d1 (.clk(clk), .rst(rst), .start(start0), .nums(nums0),
        .busy(busy1), .done(done1), .sum(sum1), .cycles(cyc1));
    sum_reduce_sched #(.N(4), .P(1)) d2 (.clk(clk), .rst(rst), .start(start2), .nums(nums2),
        .busy(busy2), .done(done2), .sum(sum2), .cycles(cyc2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic ramp();
        for (int i = 0; i < 20; i++) nums0[i*5 +: 5] = 5'(i + 1);
    endtask

    // Called at a negedge; accepts on the next edge and checks the whole run.
    task automatic run0(input string tag, input logic [31:0] exp_sum, input bit noise);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk({tag, "_busy"}, {busy0, done0}, 2'b10);
            if (noise) begin
                start0 = (k % 2 == 0);
                nums0  = ~nums0;
            end
            @(negedge clk);
        end
        start0 = 1'b0;
        chk({tag, "_done"}, {busy0, done0}, 2'b01);
        chk({tag, "_sum"}, sum0, exp_sum);
        chk({tag, "_cyc"}, cyc0, 5);
        @(negedge clk);
        chk({tag, "_pulse"}, done0, 0);
    endtask

    initial begin
        logic seen;
        rst = 1'b1; start0 = 1'b0; start2 = 1'b0; nums0 = '0; nums2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", {busy0, done0}, 0);
        chk("rst_sum", sum0, 0);
        chk("rst_cyc", cyc0, 0);
        rst = 1'b0;
        @(negedge clk);
        ramp();
        run0("t1", 210, 1'b0);
        for (int i = 0; i < 20; i++) nums0[i*5 +: 5] = 5'd31;
        run0("t2", 620, 1'b0);
        chk("t2_ow8_sum", sum1, 108);
        chk("t2_ow8_cyc", cyc1, 5);
        nums2 = {5'd9, 5'd7, 5'd5, 5'd3};
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 4; k >= 2; k--) begin
            chk("t3_l", d2.l_q, k);
            chk("t3_busy", busy2, 1);
            @(negedge clk);
        end
        chk("t3_l", d2.l_q, 1);
        chk("t3_done", done2, 1);
        chk("t3_sum", sum2, 24);
        chk("t3_cyc", cyc2, 3);
        ramp();
        run0("t4", 210, 1'b1);
        ramp();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_busy_pre", busy0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_state", {busy0, done0}, 0);
        chk("t5_sum", sum0, 0);
        chk("t5_cyc", cyc0, 0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= done0;
        end
        chk("t5_no_done", seen, 0);
        run0("t5_rerun", 210, 1'b0);
        start0 = 1'b1;
        for (int n = 0; n < 18; n++) begin
            @(negedge clk);
            chk("t6_done", done0, (n % 6 == 5));
            if (n % 6 == 5) chk("t6_sum", sum0, 210);
        end
        start0 = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
